// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
package shift_pkg;

   localparam int unsigned SHIFT_N      = 32;
   localparam int unsigned SHIFT_STAGES = 5;

   typedef enum logic [1:0] {
      SHIFT_SLL     = 2'd0,
      SHIFT_SRL     = 2'd1,
      SHIFT_SRA     = 2'd2,
      SHIFT_ILLEGAL = 2'd3
   } shift_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between issue logic, the shift sequencer and writeback.
interface shift_sequencer_if;
   import shift_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic [SHIFT_N-1:0]           in_data;
   logic [SHIFT_STAGES-1:0]      in_shamt;
   logic [1:0]                   in_op;
   logic                         out_valid;
   logic                         out_ready;
   logic [SHIFT_N-1:0]           out_data;
   logic                         out_err;
   logic                         busy;

   modport master (
      output in_valid, in_data, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_err, busy
   );

   modport slave (
      input  in_valid, in_data, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_data, out_err, busy
   );

endinterface

// File: rtl/shift_stage.sv
// One logarithmic shifter stage: shifts by 2^index when enabled, else passes through.
module shift_stage
   import shift_pkg::*;
(
   input  logic [SHIFT_N-1:0] value,
   input  logic [2:0]         index,
   input  logic               en,
   input  shift_op_t          op,
   input  logic               sign,
   output logic [SHIFT_N-1:0] result
);

   localparam logic [SHIFT_N-1:0] ALL_ONES = '1;

   logic [5:0]         amt;
   logic [SHIFT_N-1:0] fill_mask;

   always_comb begin
      amt       = 6'd1 << index;
      // Bits vacated by a right shift; SRA fills them with the captured sign.
      fill_mask = ~(ALL_ONES >> amt);
      result    = value;
      if (en) begin
         case (op)
            SHIFT_SLL: result = value << amt;
            SHIFT_SRL: result = value >> amt;
            SHIFT_SRA: result = (value >> amt) | (fill_mask & {SHIFT_N{sign}});
            default:   result = value;
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a 32-bit log shifter one stage per clock (SLL/SRL/SRA) with valid/ready on both sides.
// Optional SHIFT_SEQ_EARLY_DONE_EN: finish as soon as no higher shamt bits remain.
module shift_sequencer
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   shift_sequencer_if.slave  bus
);

   localparam int unsigned      CNT_W      = $clog2(SHIFT_STAGES);
   localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(SHIFT_STAGES - 1);

   seq_state_t              state_q;
   seq_state_t              state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [SHIFT_N-1:0]      work_q;
   logic [SHIFT_N-1:0]      stage_out;
   logic [SHIFT_STAGES-1:0] shamt_q;
   shift_op_t               op_q;
   logic                    sign_q;
   logic                    err_q;
   logic                    in_illegal;
   logic                    last_edge;

   shift_stage u_stage (
      .value  (work_q),
      .index  (cnt_q),
      .en     (shamt_q[cnt_q]),
      .op     (op_q),
      .sign   (sign_q),
      .result (stage_out)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      in_illegal = (shift_op_t'(bus.in_op) == SHIFT_ILLEGAL);
      last_edge  = (cnt_q == LAST_STAGE);
`ifdef SHIFT_SEQ_EARLY_DONE_EN
      last_edge  = last_edge || ((shamt_q >> (cnt_q + CNT_W'(1))) == '0);
`endif
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
`ifdef SHIFT_SEQ_EARLY_DONE_EN
               state_d = (in_illegal || bus.in_shamt == '0) ? DONE : SHIFT;
`else
               state_d = in_illegal ? DONE : SHIFT;
`endif
            end
         end
         SHIFT:   if (last_edge) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.out_data  = work_q;
      bus.out_err   = err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         work_q  <= '0;
         shamt_q <= '0;
         op_q    <= SHIFT_SLL;
         sign_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  work_q  <= bus.in_data;
                  shamt_q <= bus.in_shamt;
                  op_q    <= shift_op_t'(bus.in_op);
                  sign_q  <= bus.in_data[SHIFT_N-1];
                  cnt_q   <= '0;
                  err_q   <= in_illegal;
               end
            end
            SHIFT: begin
               work_q <= stage_out;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            DONE: begin
               if (bus.out_ready) err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
